frame_shadow: RTL and testbench

- Receiving end of the plot interface (`vga_plot`/`vga_x`/`vga_y`/`vga_colour`) driven by the screen and game drawing blocks.
- Holds a shadow copy of the 160x120x3 screen so game logic can read back pixel colours (e.g. wall or body detection).
- Counts accepted and rejected plots.
- Provides a clear sweep using the team's start/waitrequest handshake.

---
 rtl/frame_shadow.sv | 158 +++++++++++++++
 tb/tb_frame_shadow.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/frame_shadow.sv
// Shadow copy of the 160x120x3 plot surface with readback, plot counters and a clear sweep.
// Optional sticky overdraw detection is built when PLOT_COLLISION_EN is defined.
module frame_shadow #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vga_plot,
  input  logic [7:0]       vga_x,
  input  logic [6:0]       vga_y,
  input  logic [2:0]       vga_colour,
  input  logic             clear_start,
  output logic             clear_waitrequest,
  input  logic             rd_en,
  input  logic [7:0]       rd_x,
  input  logic [6:0]       rd_y,
  output logic             rd_valid,
  output logic [2:0]       rd_colour,
  output logic [CNT_W-1:0] plot_count,
  output logic [7:0]       oob_count,
  output logic             collision
);

  localparam int         DEPTH = SCREEN_W * SCREEN_H;
  localparam logic [14:0] LAST = 15'(DEPTH - 1);
  localparam logic [7:0]  XLIM = 8'(SCREEN_W);
  localparam logic [6:0]  YLIM = 7'(SCREEN_H);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [14:0]      clr_addr_q, clr_addr_d;
  logic [CNT_W-1:0] plot_count_q, plot_count_d;
  logic [7:0]       oob_count_q, oob_count_d;
  logic             rd_valid_q;
  logic [2:0]       rd_colour_q;

  logic             we;
  logic [14:0]      waddr;
  logic [2:0]       wdata;
  logic             plot_accept;
  logic             clear_go;

  logic [2:0] mem [0:DEPTH-1];

  // y*160 + x built from shifts so no multiplier is needed
  function automatic logic [14:0] addr_of(input logic [7:0] x, input logic [6:0] y);
    return ({8'b0, y} << 7) + ({8'b0, y} << 5) + {7'b0, x};
  endfunction

  logic [14:0] plot_addr, rd_addr;
  logic        plot_in_range, rd_in_range;

  assign plot_addr     = addr_of(vga_x, vga_y);
  assign rd_addr       = addr_of(rd_x, rd_y);
  assign plot_in_range = (vga_x < XLIM) && (vga_y < YLIM);
  assign rd_in_range   = (rd_x < XLIM) && (rd_y < YLIM);
  assign clear_go      = (state_q == IDLE) && clear_start;

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    plot_count_d = plot_count_q;
    oob_count_d  = oob_count_q;
    we           = 1'b0;
    waddr        = plot_addr;
    wdata        = vga_colour;
    plot_accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d      = CLEAR;
          clr_addr_d   = '0;
          plot_count_d = '0;
          oob_count_d  = '0;
        end else if (vga_plot) begin
          if (plot_in_range) begin
            we          = 1'b1;
            plot_accept = 1'b1;
            if (plot_count_q != '1) plot_count_d = plot_count_q + CNT_W'(1);
          end else if (oob_count_q != 8'hFF) begin
            oob_count_d = oob_count_q + 8'd1;
          end
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_addr_q;
        wdata = 3'b000;
        if (clr_addr_q == LAST) state_d = IDLE;
        else clr_addr_d = clr_addr_q + 15'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      clr_addr_q   <= '0;
      plot_count_q <= '0;
      oob_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      plot_count_q <= plot_count_d;
      oob_count_q  <= oob_count_d;
    end
  end

  // Storage has no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q  <= 1'b0;
      rd_colour_q <= 3'b000;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_colour_q <= rd_in_range ? mem[rd_addr] : 3'b000;
    end
  end

`ifdef PLOT_COLLISION_EN
  logic       pend_q;
  logic [2:0] old_q;
  logic       collision_q;

  // Old pixel is captured at the plot edge and judged one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      old_q       <= 3'b000;
      collision_q <= 1'b0;
    end else begin
      pend_q <= plot_accept && (vga_colour != 3'b000);
      if (plot_accept) old_q <= mem[plot_addr];
      if (clear_go) collision_q <= 1'b0;
      else if (pend_q && (old_q != 3'b000)) collision_q <= 1'b1;
    end
  end

  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

  assign clear_waitrequest = (state_q == CLEAR);
  assign rd_valid          = rd_valid_q;
  assign rd_colour         = rd_colour_q;
  assign plot_count        = plot_count_q;
  assign oob_count         = oob_count_q;

endmodule

// File: tb/tb_frame_shadow.sv
// Directed bench for frame_shadow: clear timing, plot/readback, range handling, counters, reset abort.
module tb_frame_shadow;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        clear_start;
  logic        clear_waitrequest;
  logic        rd_en;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic        rd_valid;
  logic [2:0]  rd_colour;
  logic [15:0] plot_count;
  logic [7:0]  oob_count;
  logic        collision;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef PLOT_COLLISION_EN
  localparam logic COLL_EN = 1'b1;
`else
  localparam logic COLL_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  frame_shadow dut (
    .clk(clk), .rst_n(rst_n),
    .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .clear_start(clear_start), .clear_waitrequest(clear_waitrequest),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid), .rd_colour(rd_colour),
    .plot_count(plot_count), .oob_count(oob_count), .collision(collision)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    vga_plot = 1'b1; vga_x = x; vga_y = y; vga_colour = c;
    tick();
    vga_plot = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] x, input logic [6:0] y, input logic [2:0] exp);
    rd_en = 1'b1; rd_x = x; rd_y = y;
    tick();
    rd_en = 1'b0;
    chk({tag, "_v"}, 32'(rd_valid), 32'd1);
    chk(tag, 32'(rd_colour), 32'(exp));
  endtask

  // Pulse clear_start for one cycle and measure how long waitrequest stays high
  task automatic run_clear(input string tag);
    int cnt;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20000 && clear_waitrequest; i++) begin
      cnt++;
      tick();
    end
    chk(tag, 32'(cnt), 32'd19200);
    chk({tag, "_wr"}, 32'(clear_waitrequest), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; vga_plot = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0;
    clear_start = 1'b0; rd_en = 1'b0; rd_x = '0; rd_y = '0;
    repeat (3) tick();
    chk("rst_wr", 32'(clear_waitrequest), 32'd0);
    chk("rst_rv", 32'(rd_valid), 32'd0);
    chk("rst_rc", 32'(rd_colour), 32'd0);
    chk("rst_pc", 32'(plot_count), 32'd0);
    chk("rst_oob", 32'(oob_count), 32'd0);
    chk("rst_col", 32'(collision), 32'd0);
    rst_n = 1'b1;
    tick();

    run_clear("clr1_len");
    rd("clr1_00", 8'd0, 7'd0, 3'b000);
    rd("clr1_max", 8'd159, 7'd119, 3'b000);
    rd("clr1_mid", 8'd80, 7'd60, 3'b000);

    plot(8'd26, 7'd6, 3'b111);
    plot(8'd32, 7'd12, 3'b010);
    rd("rd_26_6", 8'd26, 7'd6, 3'b111);
    rd("rd_32_12", 8'd32, 7'd12, 3'b010);
    chk("pc_2", 32'(plot_count), 32'd2);
    chk("oob_0", 32'(oob_count), 32'd0);

    plot(8'd160, 7'd0, 3'b111);
    plot(8'd0, 7'd120, 3'b111);
    plot(8'd255, 7'd127, 3'b111);
    chk("oob_3", 32'(oob_count), 32'd3);
    chk("pc_keep", 32'(plot_count), 32'd2);
    rd("rd_oob", 8'd160, 7'd0, 3'b000);
    rd("rd_26_6b", 8'd26, 7'd6, 3'b111);
    rd("rd_0_119", 8'd0, 7'd119, 3'b000);
    tick();
    chk("rv_idle", 32'(rd_valid), 32'd0);
    chk("rc_hold", 32'(rd_colour), 32'd0);

    // Plot coincident with clear_start, then more plots while clearing
    vga_plot = 1'b1; vga_x = 8'd10; vga_y = 7'd10; vga_colour = 3'b101;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("clr2_pc0", 32'(plot_count), 32'd0);
    chk("clr2_oob0", 32'(oob_count), 32'd0);
    chk("clr2_wr", 32'(clear_waitrequest), 32'd1);
    repeat (3) tick();
    vga_x = 8'd200;
    repeat (2) tick();
    vga_plot = 1'b0;
    chk("clr2_pcd", 32'(plot_count), 32'd0);
    chk("clr2_oobd", 32'(oob_count), 32'd0);
    for (int i = 0; i < 20000 && clear_waitrequest; i++) tick();
    chk("clr2_done", 32'(clear_waitrequest), 32'd0);
    rd("rd_10_10", 8'd10, 7'd10, 3'b000);
    rd("rd_26_6c", 8'd26, 7'd6, 3'b000);
    chk("clr2_pc", 32'(plot_count), 32'd0);

    // Read-before-write on (5,5)
    plot(8'd5, 7'd5, 3'b001);
    vga_plot = 1'b1; vga_x = 8'd5; vga_y = 7'd5; vga_colour = 3'b110;
    rd_en = 1'b1; rd_x = 8'd5; rd_y = 7'd5;
    tick();
    vga_plot = 1'b0; rd_en = 1'b0;
    chk("rbw_old", 32'(rd_colour), 32'd1);
    chk("col_early", 32'(collision), 32'd0);
    rd("rbw_new", 8'd5, 7'd5, 3'b110);
    chk("col_set", 32'(collision), 32'(COLL_EN));
    chk("pc_rbw", 32'(plot_count), 32'd2);
    plot(8'd6, 7'd6, 3'b000);
    plot(8'd6, 7'd6, 3'b011);
    tick();
    chk("col_sticky", 32'(collision), 32'(COLL_EN));
    tick();
    chk("rc_hold2", 32'(rd_colour), 32'd6);

    // Reset in the middle of a sweep
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("clr3_col0", 32'(collision), 32'd0);
    chk("clr3_pc0", 32'(plot_count), 32'd0);
    repeat (4999) tick();
    chk("clr3_busy", 32'(clear_waitrequest), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_wr", 32'(clear_waitrequest), 32'd0);
    chk("arst_rv", 32'(rd_valid), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_wr", 32'(clear_waitrequest), 32'd0);
    plot(8'd1, 7'd1, 3'b100);
    chk("post_rst_pc", 32'(plot_count), 32'd1);
    run_clear("clr4_len");
    rd("rd_1_1", 8'd1, 7'd1, 3'b000);
    rd("rd_5_5", 8'd5, 7'd5, 3'b000);
    chk("clr4_col", 32'(collision), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
